// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared constants and encodings for the GPR writeback arbiter.
// The width constants are also the design parameters, so every file agrees on them.
package gpr_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 1 << ADDR_W;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/gpr_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. When both requesters contend, the one that was not
// granted last wins. The last-grant pointer moves only when a grant is issued.
module rr_arb2
    import gpr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    req_id_e rr_last_q, rr_last_d;

    // A grant always produces a transfer, because grant is only given to a valid requester.
    always_comb begin
        grant_o   = 2'b00;
        rr_last_d = rr_last_q;
        if (req_i[0] && (!req_i[1] || rr_last_q == REQ_B)) begin
            grant_o[0] = 1'b1;
            rr_last_d  = REQ_A;
        end else if (req_i[1]) begin
            grant_o[1] = 1'b1;
            rr_last_d  = REQ_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= REQ_B;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the GPR write port between the ALU (A) and the load unit (B), tracks outstanding
// writes per register, and provides a drain sequence that empties that tracking.
module gpr_wb_arbiter
    import gpr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_dest,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_dest,
    input  logic [DATA_W-1:0] b_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    output logic [NREG-1:0]   busy,
    input  logic              drain_req,
    output logic              drain_done,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data
);

    // Handshake: x_ready is the combinational grant; a transfer is x_valid & x_ready on a
    // posedge. Requesters hold valid/dest/data until accepted and never derive valid from ready.
    logic [1:0]        grant;
    logic              wb_xfer;
    logic              issue_ok;
    drain_state_e      state_q, state_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wen_q;
    logic [ADDR_W-1:0] wdest_q, wdest_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   ({b_valid, a_valid}),
        .grant_o (grant)
    );

    assign a_ready = grant[0];
    assign b_ready = grant[1];
    assign wb_xfer = |grant;

    always_comb begin
        wdest_d = wdest_q;
        wdata_d = wdata_q;
        if (grant[0]) begin
            wdest_d = a_dest;
            wdata_d = a_data;
        end else if (grant[1]) begin
            wdest_d = b_dest;
            wdata_d = b_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        issue_ok = 1'b0;
        case (state_q)
            RUN: begin
                issue_ok = 1'b1;
                if (drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (busy_q == '0 && !wb_xfer && !wen_q) state_d = DONE;
            end
            DONE: begin
                state_d = drain_req ? DRAIN : RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // The clear is applied first so a same-edge re-issue of the committed register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (wen_q) busy_d[wdest_q] = 1'b0;
        if (issue_en && issue_ok) busy_d[issue_dest] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            busy_q  <= '0;
            wen_q   <= 1'b0;
            wdest_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            wen_q   <= wb_xfer;
            wdest_q <= wdest_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign drain_done     = (state_q == DONE);
    assign reg_write_en   = wen_q;
    assign reg_write_dest = wdest_q;
    assign reg_write_data = wdata_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter with a cycle-level reference model and literal spot checks.
module tb_gpr_wb_arbiter;
  import gpr_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              a_valid = 1'b0, b_valid = 1'b0;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_dest = '0, b_dest = '0, issue_dest = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic              issue_en = 1'b0, drain_req = 1'b0;
  logic [NREG-1:0]   busy;
  logic              drain_done;
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;

  int total = 0;
  int bad = 0;

  gpr_wb_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_dest         (a_dest),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_dest         (b_dest),
    .b_data         (b_data),
    .issue_en       (issue_en),
    .issue_dest     (issue_dest),
    .busy           (busy),
    .drain_req      (drain_req),
    .drain_done     (drain_done),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register file fed by the write port, used for read-back checks
  logic [DATA_W-1:0] gpr [NREG];
  always @(posedge clk) begin
    if (reg_write_en) gpr[reg_write_dest] <= reg_write_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: who may write, what reaches the port, which registers are pending,
  // and where the drain sequence stands (0 = normal, 1 = draining, 2 = done pulse)
  logic              m_last_b = 1'b1;
  logic              m_wen = 1'b0;
  logic [ADDR_W-1:0] m_wdest = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  bit                m_pending [NREG];
  int                m_mode = 0;
  logic              ga, gb, issue_ok, quiet;
  logic [NREG-1:0]   m_busy_vec;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last_b = 1'b1;
      m_wen    = 1'b0;
      m_wdest  = '0;
      m_wdata  = '0;
      foreach (m_pending[r]) m_pending[r] = 1'b0;
      m_mode   = 0;
    end else begin
      ga = a_valid && (!b_valid || m_last_b);
      gb = b_valid && !ga;
      m_busy_vec = '0;
      foreach (m_pending[r]) m_busy_vec[r] = m_pending[r];
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      chk("reg_write_en", reg_write_en, m_wen);
      chk("reg_write_dest", reg_write_dest, m_wdest);
      chk("reg_write_data", reg_write_data, m_wdata);
      chk("busy", busy, m_busy_vec);
      chk("drain_done", drain_done, m_mode == 2);

      issue_ok = (m_mode == 0);
      quiet = (m_busy_vec == '0) && !ga && !gb && !m_wen;
      if (m_wen) m_pending[m_wdest] = 1'b0;
      if (issue_en && issue_ok) m_pending[issue_dest] = 1'b1;
      if (m_mode == 0) m_mode = drain_req ? 1 : 0;
      else if (m_mode == 1) m_mode = quiet ? 2 : 1;
      else m_mode = drain_req ? 1 : 0;
      m_wen = ga || gb;
      if (ga) begin
        m_wdest = a_dest; m_wdata = a_data; m_last_b = 1'b0;
      end else if (gb) begin
        m_wdest = b_dest; m_wdata = b_data; m_last_b = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; issue_en = 0; drain_req = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int exp_gnt_a [4] = '{1, 0, 1, 0};
  int exp_dest [4] = '{1, 2, 1, 2};
  int pulses;
  logic [5:0] exp_done6 = 6'b010100;

  initial begin
    // 1: reset state, then a single ALU write
    do_reset();
    chk("rst_wen", reg_write_en, 0);
    chk("rst_dest", reg_write_dest, 0);
    chk("rst_data", reg_write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", drain_done, 0);
    a_valid = 1; a_dest = 3; a_data = 16'h1234;
    #1 chk("t1_a_ready", a_ready, 1);
    step();
    a_valid = 0;
    #1;
    chk("t1_wen", reg_write_en, 1);
    chk("t1_dest", reg_write_dest, 3);
    chk("t1_data", reg_write_data, 16'h1234);
    step();
    chk("t1_gpr3", gpr[3], 16'h1234);
    chk("t1_wen_off", reg_write_en, 0);

    // 2: both requesters contend for four cycles
    do_reset();
    a_valid = 1; a_dest = 1; a_data = 16'h00AA;
    b_valid = 1; b_dest = 2; b_data = 16'h00BB;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin a_valid = 0; b_valid = 0; end
      #1;
      if (k < 4) chk("t2_grant_a", a_ready, exp_gnt_a[k]);
      if (k >= 1) chk("t2_port_dest", reg_write_dest, exp_dest[k-1]);
      step();
    end

    // 3: issue r5, load writes r5 later; then same-edge re-issue with the commit
    do_reset();
    issue_en = 1; issue_dest = 5;
    step();
    issue_en = 0;
    #1 chk("t3_busy5_set", busy[5], 1);
    step();
    step();
    b_valid = 1; b_dest = 5; b_data = 16'h5555;
    #1 chk("t3_b_ready", b_ready, 1);
    step();
    b_valid = 0;
    #1 chk("t3_busy5_hold", busy[5], 1);
    step();
    #1 chk("t3_busy5_clr", busy[5], 0);
    issue_en = 1; issue_dest = 5;
    step();
    issue_en = 0;
    b_valid = 1; b_dest = 5; b_data = 16'h6666;
    step();
    b_valid = 0;
    issue_en = 1; issue_dest = 5;
    #1 chk("t3_wen", reg_write_en, 1);
    step();
    issue_en = 0;
    #1 chk("t3_set_wins", busy[5], 1);
    step();

    // 4: drain with r4/r6 outstanding; r7 issued while draining is dropped
    do_reset();
    issue_en = 1; issue_dest = 4;
    step();
    issue_dest = 6; drain_req = 1;
    step();
    issue_dest = 7;
    #1 chk("t4_busy46", busy, 8'b0101_0000);
    step();
    issue_en = 0;
    a_valid = 1; a_dest = 4; a_data = 16'h4444;
    step();
    a_valid = 0;
    b_valid = 1; b_dest = 6; b_data = 16'h6666;
    step();
    b_valid = 0;
    pulses = 0;
    for (int cyc = 5; cyc < 13; cyc++) begin
      #1;
      chk("t4_busy7", busy[7], 0);
      if (drain_done) begin
        pulses++;
        chk("t4_pulse_cycle", cyc, 7);
        drain_req = 0;
      end
      step();
    end
    chk("t4_pulses", pulses, 1);

    // 5: asynchronous reset in the middle of a transfer
    do_reset();
    issue_en = 1; issue_dest = 2;
    a_valid = 1; a_dest = 1; a_data = 16'h1111;
    step();
    issue_en = 0;
    b_valid = 1; b_dest = 3; b_data = 16'h3333;
    #1 chk("t5_wen_before", reg_write_en, 1);
    #1 rst_n = 0;
    #1;
    chk("t5_wen_async", reg_write_en, 0);
    chk("t5_busy_async", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1;
    chk("t5_a_first", a_ready, 1);
    chk("t5_b_wait", b_ready, 0);
    step();
    idle_inputs();
    step();

    // 6: drain while idle; held request re-pulses every two cycles
    do_reset();
    drain_req = 1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1 chk("t6_done", drain_done, exp_done6[cyc]);
      step();
    end
    drain_req = 0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
